// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: round-robin arbiter sharing one 4:1 mux-fed resource among
// four requesters. A grant is held until done, the grantee withdraws, or the
// hold limit expires; on release the next winner is granted in the same edge.
module mux_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]    grant_reg, grant_next;
  logic [1:0]    sel_reg, sel_next;
  logic          timeout_reg, timeout_next;

  logic          in_grant;
  logic          abandon;
  logic          hold_max;
  logic          rel_evt;
  logic [1:0]    scan_base;
  logic [1:0]    scan_idx [4];
  logic          win_found;
  logic [1:0]    win_idx;

  assign in_grant = (state_reg == GRANT);
  assign abandon  = ~req[sel_reg];
  assign hold_max = (hold_cnt_reg == CW'(MAX_HOLD - 1));
  assign rel_evt  = in_grant & (done | abandon | hold_max);

  // On release the scan restarts just past the outgoing grantee, so it
  // becomes lowest priority but can still win if it is alone.
  assign scan_base = in_grant ? (sel_reg + 2'd1) : ptr_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
      assign scan_idx[gi] = scan_base + 2'(gi);
    end
  endgenerate

  // Pick the first requesting index in rotated order (lowest offset wins).
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[scan_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[i];
      end
    end
  end

  // Next-state logic for the FSM, pointer, hold counter and outputs.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    sel_next      = sel_reg;
    timeout_next  = 1'b0;
    if (!in_grant) begin
      // done is ignored while idle; sel keeps its last value
      if (win_found) begin
        state_next    = GRANT;
        grant_next    = 4'b0001 << win_idx;
        sel_next      = win_idx;
        hold_cnt_next = '0;
      end
    end else if (rel_evt) begin
      ptr_next     = sel_reg + 2'd1;
      // done wins over a coincident hold-limit expiry
      timeout_next = hold_max & ~done;
      if (win_found) begin
        grant_next    = 4'b0001 << win_idx;
        sel_next      = win_idx;
        hold_cnt_next = '0;
      end else begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    end else begin
      hold_cnt_next = hold_cnt_reg + CW'(1);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      hold_cnt_reg <= '0;
      grant_reg    <= 4'b0000;
      sel_reg      <= 2'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      sel_reg      <= sel_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant       = grant_reg;
  assign sel         = sel_reg;
  assign busy        = |grant_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed bench for mux_arbiter_4: reset, sole requester, rotation,
// wrap/skip, timeout, boundary release cases and asynchronous reset.
module tb_mux_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  mux_arbiter_4 #(.MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock and settle just past the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_gs(input string tag, input logic [3:0] g, input logic [1:0] s);
    check({tag, "_grant"}, grant, g);
    check({tag, "_sel"}, {2'b00, sel}, {2'b00, s});
    check({tag, "_busy"}, {3'b000, busy}, {3'b000, |g});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #12;
    // reset state
    check_gs("reset", 4'b0000, 2'd0);
    check("reset_tmo", {3'b000, timeout_err}, 4'h0);
    rst_n = 1'b1;
    step();
    check_gs("idle_after_reset", 4'b0000, 2'd0);

    // single requester, done on the 3rd grant cycle
    req = 4'b0001;
    step();
    check_gs("single_grant", 4'b0001, 2'd0);
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check_gs("single_regrant", 4'b0001, 2'd0);
    check("single_tmo", {3'b000, timeout_err}, 4'h0);
    req = 4'b0000;
    step();
    check_gs("single_idle", 4'b0000, 2'd0);
    // done in IDLE is ignored
    done = 1'b1;
    step();
    done = 1'b0;
    check_gs("idle_done_ignored", 4'b0000, 2'd0);

    // rotation from a fresh pointer
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    check_gs("rot0", 4'b0001, 2'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rot_hold_sel", {2'b00, sel}, 4'(k - 1));
      check("rot_hold_onehot", 4'($countones(grant)), 4'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      check("rot_sel", {2'b00, sel}, 4'(k % 4));
      check("rot_onehot", 4'($countones(grant)), 4'd1);
      check("rot_busy", {3'b000, busy}, 4'h1);
    end

    // drive pointer to 3: abandon 0 -> grant 2, abandon 2 -> idle
    req = 4'b0100;
    step();
    check_gs("to2", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    check_gs("to_idle", 4'b0000, 2'd2);

    // wrap and skip with ptr=3
    req = 4'b0101;
    step();
    check_gs("wrap0", 4'b0001, 2'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    check_gs("skip2", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    check_gs("wrap_idle", 4'b0000, 2'd2);

    // timeout: ptr=3, req=0011 -> grant 0 for 16 cycles
    req = 4'b0011;
    step();
    check_gs("tmo_grant0", 4'b0001, 2'd0);
    for (int k = 0; k < 15; k++) begin
      step();
      check("tmo_hold_grant", grant, 4'b0001);
      check("tmo_hold_err", {3'b000, timeout_err}, 4'h0);
    end
    step();
    check_gs("tmo_release", 4'b0010, 2'd1);
    check("tmo_err_pulse", {3'b000, timeout_err}, 4'h1);
    step();
    check("tmo_err_clear", {3'b000, timeout_err}, 4'h0);
    check_gs("tmo_after", 4'b0010, 2'd1);

    // boundary: done on the 16th held cycle (ptr=2 after abandon)
    req = 4'b0000;
    step();
    check_gs("bnd_idle", 4'b0000, 2'd1);
    req = 4'b0011;
    step();
    check_gs("bnd_grant0", 4'b0001, 2'd0);
    for (int k = 0; k < 15; k++) step();
    check("bnd_still0", grant, 4'b0001);
    done = 1'b1;
    step();
    done = 1'b0;
    check_gs("bnd_release", 4'b0010, 2'd1);
    check("bnd_no_err", {3'b000, timeout_err}, 4'h0);
    step();
    check("bnd_no_err2", {3'b000, timeout_err}, 4'h0);

    // abandon mid-grant: drop req[1]
    req = 4'b0001;
    step();
    check_gs("abandon", 4'b0001, 2'd0);
    check("abandon_no_err", {3'b000, timeout_err}, 4'h0);

    // reset mid-grant while grant=0100
    req = 4'b0100;
    step();
    check_gs("pre_rst", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_gs("async_rst", 4'b0000, 2'd0);
    req = 4'b1111;
    #2;
    rst_n = 1'b1;
    step();
    check_gs("post_rst", 4'b0001, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_4.md
# mux_arbiter_4

Round-robin arbiter that shares one 4:1 mux-fed resource, such as a memory or bus port, among four requesters. It watches four request lines and grants exactly one requester at a time. Its registered 2-bit `sel` output drives the select of the shared `mux_4_1` (`s`). A grant is held until the resource signals `done`, the requester withdraws, or a hold-time limit expires.

## Interface
- `MAX_HOLD`, 16, maximum cycles a grant may be held before forced release; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; must stay high until served or abandoned.
- `done`  in  1  shared resource finished the current transaction (single-cycle pulse).
- `grant`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  index of the current or last grantee, registered; connects to the mux `s` input.
- `busy`  out  1  equals `|grant`.
- `timeout_err`  out  1  one-cycle pulse on forced release.

## Operation
- State: FSM {IDLE, GRANT}, round-robin pointer `ptr` (2 bits), hold counter `hold_cnt` ($clog2(MAX_HOLD) bits).
- Reset (async, `rst_n`=0): state=IDLE, `ptr`=0, `hold_cnt`=0, `grant`=0, `sel`=0, `busy`=0, `timeout_err`=0.
- Priority: scan `req` starting at index `ptr`, increasing, wrapping 3→0. The first set bit wins.
- IDLE: if `req`≠0, grant the winner: `grant`=one-hot(winner), `sel`=winner, `hold_cnt`=0, go to GRANT. Otherwise stay in IDLE; `sel` keeps its last value so the mux output stays stable.
- GRANT: a release event occurs when any of the following is true in the current cycle:
  - `done`=1 (normal completion).
  - `req[sel]`=0 (requester abandoned; no error).
  - `hold_cnt`==MAX_HOLD-1 with `done`=0 (timeout; `timeout_err`=1 for the next cycle).
- With no release event, `hold_cnt` increments and `grant`/`sel` hold.
- On a release event:
  - Set `ptr`=sel+1 (mod 4).
  - Rearbitrate in the same cycle using the new `ptr` against the current `req`. The released requester therefore gets lowest priority, but it is regranted if it is the only one still requesting.
  - If there is a winner, grant it directly with no idle bubble and reset `hold_cnt`=0. If not, go to IDLE with `grant`=0.
- `done` while in IDLE is ignored.
- `done` together with timeout: `done` takes precedence and `timeout_err` stays 0.
- `grant` is never multi-hot. `grant`≠0 implies `grant[sel]`=1.

## Timing
- Grant latency: `req` sampled high at edge k (from IDLE) gives `grant`/`sel` valid after edge k; the resource sees the new select in the cycle after the request is first seen.
- Release latency: `done` high at edge k gives a new `grant`/`sel` (or 0) after edge k. The old grantee owns the resource for exactly the cycles up to and including the `done` cycle.
- Hold limit: a grant lasts at most MAX_HOLD cycles. Release is forced on the edge where `hold_cnt`==MAX_HOLD-1.
- `timeout_err` is high for exactly one cycle, the cycle after the forced-release edge.
- Back-to-back handover has zero bubble cycles.
- Asserting `rst_n`=0 mid-grant clears `grant` immediately (asynchronously), without waiting for a clock edge.
- First arbitration after deassertion of reset occurs on the first edge with `rst_n`=1.

## Test plan
- Single requester: `req`=0001, pulse `done` on the 3rd grant cycle. Expect:
  - `grant`=0001 and `sel`=0 one edge after `req`.
  - `grant`=0001 again immediately after `done` (sole requester regranted), `ptr`=1.
- Rotation: `req`=1111 held, `done` pulsed every 2nd cycle. Expect:
  - `sel` sequence 0,1,2,3,0 with no idle cycles between grants.
  - `grant` always one-hot.
- Wrap and skip: `ptr`=3 state, `req`=0101. Expect grant 0 first, then 2 after `done`, then IDLE with `grant`=0 once `req`=0.
- Timeout: MAX_HOLD=16, `req`=0011, never pulse `done`. Expect:
  - Requester 0 holds for 16 cycles, then `timeout_err` pulses one cycle.
  - `sel`=1, `grant`=0010.
- Boundary: `done` on exactly the 16th held cycle gives normal release with `timeout_err`=0. `req[sel]` dropped mid-grant gives release with no error.
- Reset mid-grant: `rst_n`=0 between edges while `grant`=0100. Expect:
  - `grant`=0, `sel`=0, `busy`=0 asynchronously.
  - After release of reset with `req`=1111, the first grant goes to requester 0.
